// File: rtl/aes_mover_pkg.sv
// Purpose: shared types, sizes and block/word packing helpers for aes_block_mover.
// Block byte i occupies blk[127-8i -: 8]; word k of a block is the little-endian
// word {byte 4k+3, byte 4k+2, byte 4k+1, byte 4k} as it sits in memory.
package aes_mover_pkg;

  localparam int unsigned WORDS_PER_BLK  = 4;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BLK_BYTES      = 16;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BLK_W          = 128;
  localparam int unsigned CNT_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit position of the LSB of block byte idx.
  function automatic logic [6:0] byte_lsb(input int unsigned idx);
    return 7'(BLK_W - 8 - 8 * idx);
  endfunction

  // Extract memory word k from a block.
  function automatic logic [WORD_W-1:0] blk_to_word(input logic [BLK_W-1:0] blk,
                                                    input logic [CNT_W-1:0] k);
    logic [WORD_W-1:0] w;
    logic [6:0]        lsb;
    w = '0;
    // Byte 4k is shifted in first so it ends up in the low lane.
    for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
      lsb = byte_lsb(BYTES_PER_WORD * 32'(k) + b);
      w   = {blk[lsb +: 8], w[WORD_W-1:8]};
    end
    return w;
  endfunction

  // Return blk with slot k replaced by memory word w.
  function automatic logic [BLK_W-1:0] word_to_blk(input logic [BLK_W-1:0]  blk,
                                                   input logic [WORD_W-1:0] w,
                                                   input logic [CNT_W-1:0]  k);
    logic [BLK_W-1:0]  r;
    logic [WORD_W-1:0] sh;
    logic [6:0]        lsb;
    r  = blk;
    sh = w;
    for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
      lsb         = byte_lsb(BYTES_PER_WORD * 32'(k) + b);
      r[lsb +: 8] = sh[7:0];
      sh          = sh >> 8;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_block_mover.sv
// Purpose: bus initiator moving one 128-bit AES block between data memory and
// the AES datapath (LOAD: 4 word reads -> blk_out, STORE: blk_in -> 4 word writes).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, dir, base_addr    command strobe, 0=LOAD/1=STORE, byte base address
//   blk_in / blk_out         block to store / last successfully loaded block
//   busy, done, err          in-flight flag, 1-cycle completion pulse, reject flag
//   mem_addr, mem_wdata      memory address / write data
//   mem_read, mem_write      memory strobes (never both high)
//   mem_rdata                combinational memory read data
// Configuration: define AES_MOVER_RANGE_CHECK_EN to reject misaligned or
// out-of-range base addresses; otherwise every command is executed with
// 32-bit address wrap and err stays 0.
module aes_block_mover
  import aes_mover_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  input  logic [31:0]  base_addr,
  input  logic [127:0] blk_in,
  output logic [127:0] blk_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [31:0]  mem_rdata
);

`ifdef AES_MOVER_RANGE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLK - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   hold_q, hold_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [BLK_W-1:0]   blk_out_q, blk_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WORD_W-1:0]  mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;

  logic misaligned_c;
  logic out_of_range_c;
  logic reject_c;

  // Command rejection; the 33-bit sum keeps high base addresses from wrapping.
  assign misaligned_c   = (base_addr[1:0] != 2'b00);
  assign out_of_range_c = (({1'b0, base_addr} + 33'(BLK_BYTES)) > 33'(MEM_SIZE));
  assign reject_c       = CHECK_EN && (misaligned_c || out_of_range_c);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    blk_d       = blk_q;
    blk_out_d   = blk_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          blk_d  = blk_in;
          if (reject_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            // First access is launched on the accepting edge.
            mem_addr_d = base_addr;
            if (dir) begin
              state_d     = ST_STORE;
              mem_write_d = 1'b1;
              mem_wdata_d = blk_to_word(blk_in, '0);
            end else begin
              state_d    = ST_LOAD;
              mem_read_d = 1'b1;
            end
          end
        end
      end

      ST_LOAD: begin
        hold_d = word_to_blk(hold_q, mem_rdata, cnt_q);
        if (cnt_q == CNT_LAST) begin
          // Last word joins the holding register on the same edge blk_out updates.
          state_d   = ST_DONE;
          done_d    = 1'b1;
          blk_out_d = hold_d;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_addr_d = mem_addr_q + 32'd4;
          mem_read_d = 1'b1;
        end
      end

      ST_STORE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d       = cnt_q + 2'd1;
          mem_addr_d  = mem_addr_q + 32'd4;
          mem_write_d = 1'b1;
          mem_wdata_d = blk_to_word(blk_q, cnt_q + 2'd1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      blk_q       <= '0;
      blk_out_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      blk_q       <= blk_d;
      blk_out_q   <= blk_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign blk_out   = blk_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_aes_block_mover.sv
// Testbench for aes_block_mover: byte-array memory, reference memory model,
// directed scenarios followed by randomized LOAD/STORE commands.
module tb_aes_block_mover;

`ifdef AES_MOVER_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         dir;
  logic [31:0]  base_addr;
  logic [127:0] blk_in;
  logic [127:0] blk_out;
  logic         busy;
  logic         done;
  logic         err;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_rdata;

  logic [7:0]   mem     [256];
  logic [7:0]   ref_mem [256];
  logic         init_en;

  int           checks   = 0;
  int           failures = 0;
  logic [127:0] exp_blk_out;

  always #5 clk = ~clk;

  aes_block_mover dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .base_addr (base_addr),
    .blk_in    (blk_in),
    .blk_out   (blk_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Byte-addressable little-endian memory, 8-bit address wrap.
  always @(posedge clk) begin
    if (init_en) begin
      mem <= ref_mem;
    end else if (mem_write) begin
      mem[8'(mem_addr)]          <= mem_wdata[7:0];
      mem[8'(mem_addr + 32'd1)]  <= mem_wdata[15:8];
      mem[8'(mem_addr + 32'd2)]  <= mem_wdata[23:16];
      mem[8'(mem_addr + 32'd3)]  <= mem_wdata[31:24];
    end
  end

  assign mem_rdata = {mem[8'(mem_addr + 32'd3)], mem[8'(mem_addr + 32'd2)],
                      mem[8'(mem_addr + 32'd1)], mem[8'(mem_addr)]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_reject(input logic [31:0] b);
    return RC_EN && ((b[1:0] != 2'b00) || (({1'b0, b} + 33'd16) > 33'd256));
  endfunction

  // Byte i of a block (byte 0 is the most significant byte).
  function automatic logic [7:0] blk_byte(input logic [127:0] blk, input int i);
    return 8'(blk >> (8 * (15 - i)));
  endfunction

  function automatic logic [31:0] exp_word(input logic [127:0] blk, input int k);
    return {blk_byte(blk, 4*k+3), blk_byte(blk, 4*k+2), blk_byte(blk, 4*k+1), blk_byte(blk, 4*k)};
  endfunction

  // Block as it currently sits in the reference memory at base b.
  function automatic logic [127:0] model_block(input logic [31:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = (r << 8) | 128'(ref_mem[8'(b + 32'(i))]);
    return r;
  endfunction

  task automatic model_store(input logic [31:0] b, input logic [127:0] blk, input int nbytes);
    for (int i = 0; i < nbytes; i++) ref_mem[8'(b + 32'(i))] = blk_byte(blk, i);
  endtask

  task automatic mem_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[8'(i)] !== ref_mem[8'(i)]) bad++;
    chk(tag, 128'(bad), 128'(0));
  endtask

  // One command issued from IDLE, checked cycle by cycle; returns in IDLE.
  task automatic run_cmd(input logic d, input logic [31:0] b, input logic [127:0] blk);
    bit           rej;
    logic [127:0] exp_load;
    rej      = exp_reject(b);
    exp_load = model_block(b);
    start = 1'b1; dir = d; base_addr = b; blk_in = blk;
    tick();
    start = 1'b0; dir = 1'($urandom); base_addr = $urandom;
    blk_in = {$urandom, $urandom, $urandom, $urandom};
    if (rej) begin
      chk("rej_done", 128'(done), 128'(1));
      chk("rej_err", 128'(err), 128'(1));
      chk("rej_noaccess", 128'({mem_read, mem_write}), 128'(0));
      chk("rej_blk_out", blk_out, exp_blk_out);
      tick();
      chk("rej_idle", 128'({busy, done, mem_read, mem_write}), 128'(0));
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("acc_read", 128'(mem_read), 128'(!d));
        chk("acc_write", 128'(mem_write), 128'(d));
        chk("acc_addr", 128'(mem_addr), 128'(b + 32'(4*k)));
        if (d) chk("acc_wdata", 128'(mem_wdata), 128'(exp_word(blk, k)));
        chk("acc_busy_done", 128'({busy, done}), 128'(2'b10));
        tick();
      end
      chk("done_flags", 128'({busy, done, err}), 128'(3'b110));
      chk("done_noaccess", 128'({mem_read, mem_write}), 128'(0));
      if (!d) exp_blk_out = exp_load;
      else    model_store(b, blk, 16);
      chk("done_blk_out", blk_out, exp_blk_out);
      tick();
      chk("idle_flags", 128'({busy, done, mem_read, mem_write}), 128'(0));
    end
  endtask

  initial begin
    int           writes, dones, reads, adjacent;
    logic         prev_done;
    logic         busy_c6;
    logic [127:0] blk_r;
    logic [127:0] tp_blk;

    rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; blk_in = '0;
    init_en = 1'b0; exp_blk_out = '0;
    for (int i = 0; i < 256; i++) ref_mem[8'(i)] = 8'($urandom);
    for (int i = 0; i < 16; i++) ref_mem[8'(16 + i)] = 8'(i);
    init_en = 1'b1;
    tick();
    tick();
    init_en = 1'b0;
    chk("reset_flags", 128'({busy, done, err, mem_read, mem_write}), 128'(0));
    chk("reset_bus", 128'({mem_addr, mem_wdata}), 128'(0));
    chk("reset_blk_out", blk_out, 128'(0));
    rst = 1'b0;
    tick();

    // Directed: known-pattern load and store/reload.
    run_cmd(1'b0, 32'h10, 128'h0);
    chk("tp_load_value", blk_out, 128'h000102030405060708090A0B0C0D0E0F);
    tp_blk = 128'h00112233445566778899AABBCCDDEEFF;
    run_cmd(1'b1, 32'h20, tp_blk);
    chk("tp_store_word0", 128'({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}), 128'(32'h33221100));
    chk("tp_store_word3", 128'({mem[8'h2F], mem[8'h2E], mem[8'h2D], mem[8'h2C]}), 128'(32'hFFEEDDCC));
    run_cmd(1'b0, 32'h20, 128'h0);
    chk("tp_reload", blk_out, tp_blk);

    // Boundary bases: misaligned, past the end, last legal block.
    run_cmd(1'b0, 32'h22, 128'h0);
    run_cmd(1'b0, 32'hF4, 128'h0);
    run_cmd(1'b0, 32'hF0, 128'h0);
    run_cmd(1'b1, 32'hFFFF_FFF0, {4{$urandom}});
    mem_check("boundary_mem");

    // start pulses during a STORE and in DONE must be ignored.
    blk_r = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1; dir = 1'b1; base_addr = 32'h80; blk_in = blk_r;
    writes = 0; dones = 0; busy_c6 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = (c == 2 || c == 5);
      if (mem_write) writes++;
      if (done) dones++;
      if (c == 6) busy_c6 = busy;
    end
    start = 1'b0;
    model_store(32'h80, blk_r, 16);
    chk("ignore_writes", 128'(writes), 128'(4));
    chk("ignore_dones", 128'(dones), 128'(1));
    chk("ignore_idle_c6", 128'(busy_c6), 128'(0));
    mem_check("ignore_mem");

    // Reset during a STORE after two words have been written.
    blk_r = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1; dir = 1'b1; base_addr = 32'h40; blk_in = blk_r;
    tick();
    start = 1'b0;
    chk("abort_w0_addr", 128'({mem_write, mem_addr}), 128'({1'b1, 32'h40}));
    tick();
    chk("abort_w1_addr", 128'({mem_write, mem_addr}), 128'({1'b1, 32'h44}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_flags", 128'({busy, done, err, mem_read, mem_write}), 128'(0));
    chk("abort_bus", 128'({mem_addr, mem_wdata}), 128'(0));
    chk("abort_blk_out", blk_out, 128'(0));
    exp_blk_out = '0;
    model_store(32'h40, blk_r, 8);
    mem_check("abort_mem");
    run_cmd(1'b0, 32'h40, 128'h0);

    // start held high: one command every 6 cycles.
    start = 1'b1; dir = 1'b0; base_addr = 32'h10; blk_in = '0;
    dones = 0; reads = 0; adjacent = 0; prev_done = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (done) dones++;
      if (done && prev_done) adjacent++;
      prev_done = done;
      if (mem_read) reads++;
    end
    start = 1'b0;
    exp_blk_out = model_block(32'h10);
    chk("held_dones", 128'(dones), 128'(5));
    chk("held_adjacent", 128'(adjacent), 128'(0));
    chk("held_reads", 128'(reads), 128'(20));
    chk("held_blk_out", blk_out, exp_blk_out);
    chk("held_idle", 128'(busy), 128'(0));

    // Randomized commands against the reference memory.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0, 1:    b = 32'(4 * $urandom_range(0, 60));
        2:       b = 32'($urandom_range(0, 250));
        default: b = $urandom;
      endcase
      run_cmd(1'($urandom), b, {$urandom, $urandom, $urandom, $urandom});
    end
    mem_check("random_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
